// File: rtl/cd_rx_page_mgr_pkg.sv
// Shared constants for the rx page manager: ready-entry layout and lost-counter width.
package cd_rx_page_pkg;
    localparam int PAGE_NUM_DEF = 4;
    localparam int LEN_W        = 8;   // ready entry = {page, len}
    localparam int LOST_W       = 8;
endpackage

// File: rtl/cd_rx_page_mgr_if.sv
// Bus between the rx page manager and its clients (byte assembler + host).
interface cd_rx_page_mgr_if
    import cd_rx_page_pkg::*;
#(
    parameter int PAGE_AW = 2
);
    logic                 rx_switch;
    logic [LEN_W-1:0]     rx_len;
    logic [PAGE_AW-1:0]   rx_wr_page;
    logic                 rx_avail;
    logic [PAGE_AW-1:0]   rx_rd_page;
    logic [LEN_W-1:0]     rx_rd_len;
    logic [PAGE_AW:0]     rx_pend;
    logic                 rx_release;
    logic                 rx_flush;
    logic                 rx_lost;
    logic [LOST_W-1:0]    rx_lost_cnt;

    modport master (
        output rx_switch, rx_len, rx_release, rx_flush,
        input  rx_wr_page, rx_avail, rx_rd_page, rx_rd_len, rx_pend, rx_lost, rx_lost_cnt
    );
    modport slave (
        input  rx_switch, rx_len, rx_release, rx_flush,
        output rx_wr_page, rx_avail, rx_rd_page, rx_rd_len, rx_pend, rx_lost, rx_lost_cnt
    );
endinterface

// File: rtl/cd_rx_page_mgr_fifo.sv
// Circular FIFO with register-only head/count outputs. SEQ_INIT variant comes up
// (and reinits) holding base+1 .. base+DEPTH-1, used for the free page list.
module cd_page_fifo #(
    parameter int W        = 2,
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter bit SEQ_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          reinit,
    input  logic [W-1:0]  reinit_base,
    output logic [W-1:0]  head,
    output logic [AW:0]   count
);
    localparam logic [AW-1:0] INIT_WR  = AW'(SEQ_INIT ? DEPTH - 1 : 0);
    localparam logic [AW:0]   INIT_CNT = (AW+1)'(SEQ_INIT ? DEPTH - 1 : 0);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= SEQ_INIT ? W'(i + 1) : '0;
            rd_ptr <= '0;
            wr_ptr <= INIT_WR;
            count  <= INIT_CNT;
        end else if (reinit) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= SEQ_INIT ? reinit_base + W'(i + 1) : '0;
            rd_ptr <= '0;
            wr_ptr <= INIT_WR;
            count  <= INIT_CNT;
        end else begin
            // Callers never push when full nor pop when empty, so push+pop never aliases a slot.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/cd_rx_page_mgr.sv
// Rx page scheduler: owns the assembler's write page, queues committed pages for the host,
// recycles released pages. Optional saturating drop counter under CD_RX_LOST_CNT_EN.
module cd_rx_page_mgr
    import cd_rx_page_pkg::*;
#(
    parameter int PAGE_NUM = PAGE_NUM_DEF,
    parameter int PAGE_AW  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cd_rx_page_mgr_if.slave      bus
);
    localparam int EW = PAGE_AW + LEN_W;

    logic [PAGE_AW-1:0] wr_page, free_head;
    logic [PAGE_AW:0]   free_cnt, rdy_cnt;
    logic [EW-1:0]      rdy_head;
    logic               rel_ok, commit, free_empty, bypass, commit_ok, lost, lost_q;
    logic               free_push, free_pop;

    // Flush wins over everything; a release needs a queued page to act on.
    assign rel_ok     = !bus.rx_flush && bus.rx_release && (rdy_cnt != '0);
    assign commit     = !bus.rx_flush && bus.rx_switch;
    assign free_empty = (free_cnt == '0);
    assign bypass     = commit && rel_ok && free_empty;
    assign commit_ok  = commit && (!free_empty || rel_ok);
    assign lost       = commit && free_empty && !rel_ok;
    assign free_push  = rel_ok && !bypass;
    assign free_pop   = commit_ok && !free_empty;

    cd_page_fifo #(.W(PAGE_AW), .DEPTH(PAGE_NUM), .AW(PAGE_AW), .SEQ_INIT(1'b1)) u_free (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (free_push),
        .push_data   (rdy_head[EW-1:LEN_W]),
        .pop         (free_pop),
        .reinit      (bus.rx_flush),
        .reinit_base (wr_page),
        .head        (free_head),
        .count       (free_cnt)
    );

    cd_page_fifo #(.W(EW), .DEPTH(PAGE_NUM), .AW(PAGE_AW), .SEQ_INIT(1'b0)) u_ready (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (commit_ok),
        .push_data   ({wr_page, bus.rx_len}),
        .pop         (rel_ok),
        .reinit      (bus.rx_flush),
        .reinit_base ('0),
        .head        (rdy_head),
        .count       (rdy_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_page <= '0;
            lost_q  <= 1'b0;
        end else begin
            lost_q <= lost;
            // With no free page, the page just released goes straight back to the assembler.
            if (commit_ok)
                wr_page <= bypass ? rdy_head[EW-1:LEN_W] : free_head;
        end
    end

`ifdef CD_RX_LOST_CNT_EN
    logic [LOST_W-1:0] lost_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lost_cnt <= '0;
        else if (bus.rx_flush)
            lost_cnt <= '0;
        else if (lost && lost_cnt != '1)
            lost_cnt <= lost_cnt + 1'b1;
    end
    assign bus.rx_lost_cnt = lost_cnt;
`else
    assign bus.rx_lost_cnt = '0;
`endif

    assign bus.rx_wr_page = wr_page;
    assign bus.rx_avail   = (rdy_cnt != '0);
    assign bus.rx_pend    = rdy_cnt;
    assign bus.rx_rd_page = rdy_head[EW-1:LEN_W];
    assign bus.rx_rd_len  = rdy_head[LEN_W-1:0];
    assign bus.rx_lost    = lost_q;
endmodule
